// File: rtl/dm_access_stage.sv
// dm_access_stage: SimpleRISC memory-access stage with req/ack memory port, timeout and DM->RW register.
// Optional misaligned-access trap enabled by defining DM_ALIGN_CHECK_EN.
module dm_access_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] aluResult_DM,
  input  logic [31:0] op2_DM,
  input  logic [4:0]  rd_DM,
  input  logic        isWb_DM,
  input  logic        isLd_DM,
  input  logic        isSt_DM,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] aluResult_RW,
  output logic [31:0] ldResult_RW,
  output logic [4:0]  rd_RW,
  output logic        isWb_RW,
  output logic        isLd_RW,
  output logic        memErr_RW,
  output logic        misalign_RW
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic req_q, req_d, we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, alu_q, alu_d, ld_q, ld_d;
  logic [4:0] rd_q, rd_d;
  logic wb_q, wb_d, isld_q, isld_d, err_q, err_d, mis_q, mis_d;
  logic memop, misal, timeout;
  assign memop = isLd_DM | isSt_DM;
`ifdef DM_ALIGN_CHECK_EN
  assign misal = memop && (aluResult_DM[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif
  assign timeout = cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    alu_d   = alu_q;
    ld_d    = ld_q;
    rd_d    = rd_q;
    wb_d    = 1'b0;
    isld_d  = 1'b0;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    stall   = 1'b0;
    if (state_q == IDLE) begin
      if (misal) begin
        alu_d = aluResult_DM;
        rd_d  = rd_DM;
        mis_d = 1'b1;
      end else if (memop) begin
        stall   = 1'b1;
        state_d = BUSY;
        req_d   = 1'b1;
        we_d    = isSt_DM;
        addr_d  = aluResult_DM[31:2];
        wdata_d = op2_DM;
        cnt_d   = '0;
      end else begin
        alu_d = aluResult_DM;
        rd_d  = rd_DM;
        wb_d  = isWb_DM;
      end
    end else begin
      stall = !mem_ack && !timeout;
      if (mem_ack) begin
        state_d = IDLE;
        req_d   = 1'b0;
        alu_d   = aluResult_DM;
        rd_d    = rd_DM;
        wb_d    = isWb_DM;
        isld_d  = isLd_DM;
        ld_d    = isLd_DM ? mem_rdata : ld_q;
      end else if (timeout) begin
        state_d = IDLE;
        req_d   = 1'b0;
        alu_d   = aluResult_DM;
        rd_d    = rd_DM;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    stall = stall && !rst;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      alu_q   <= '0;
      ld_q    <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      isld_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      alu_q   <= alu_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      isld_q  <= isld_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign aluResult_RW = alu_q;
  assign ldResult_RW  = ld_q;
  assign rd_RW        = rd_q;
  assign isWb_RW      = wb_q;
  assign isLd_RW      = isld_q;
  assign memErr_RW    = err_q;
  assign misalign_RW  = mis_q;
endmodule

// File: tb/tb_dm_access_stage.sv
// tb_dm_access_stage: directed test-plan scenarios plus random traffic against a transaction-level model.
module tb_dm_access_stage;
  localparam int TIMEOUT = 15;
`ifdef DM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, isWb_DM, isLd_DM, isSt_DM, mem_ack;
  logic [31:0] aluResult_DM, op2_DM, mem_rdata;
  logic [4:0] rd_DM;
  logic stall, mem_req, mem_we, isWb_RW, isLd_RW, memErr_RW, misalign_RW;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, aluResult_RW, ldResult_RW;
  logic [4:0] rd_RW;
  dm_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .aluResult_DM(aluResult_DM), .op2_DM(op2_DM), .rd_DM(rd_DM),
    .isWb_DM(isWb_DM), .isLd_DM(isLd_DM), .isSt_DM(isSt_DM), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .aluResult_RW(aluResult_RW),
    .ldResult_RW(ldResult_RW), .rd_RW(rd_RW), .isWb_RW(isWb_RW), .isLd_RW(isLd_RW),
    .memErr_RW(memErr_RW), .misalign_RW(misalign_RW)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0, stall_cnt = 0, req_cnt = 0;
  // Model: whether an access is outstanding, which BUSY cycle we are in, and expected registers.
  bit m_busy = 0;
  int m_wait = 0;
  bit exp_stall = 0;
  logic e_req = 0, e_we = 0, e_wb = 0, e_isld = 0, e_err = 0, e_mis = 0;
  logic [29:0] e_addr = 0;
  logic [31:0] e_wdata = 0, e_alu = 0, e_ld = 0;
  logic [4:0] e_rd = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic bubble();
    e_wb = 0; e_isld = 0; e_err = 0; e_mis = 0;
  endtask
  // Called at a negedge: drive one cycle, check stall, clock it, then check registered outputs.
  task automatic cyc(input logic r, input logic [31:0] alu, input logic [31:0] op2, input logic [4:0] rd,
                     input logic wb, input logic ld, input logic st, input logic ack, input logic [31:0] rdata);
    rst = r; aluResult_DM = alu; op2_DM = op2; rd_DM = rd;
    isWb_DM = wb; isLd_DM = ld; isSt_DM = st; mem_ack = ack; mem_rdata = rdata;
    if (r) exp_stall = 0;
    else if (!m_busy) exp_stall = (ld | st) && !(ALIGN && alu[1:0] != 2'b00);
    else exp_stall = !ack && m_wait < TIMEOUT;
    #1;
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    stall_cnt += int'(stall);
    req_cnt += int'(mem_req);
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_wait = 0;
      e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_alu = 0; e_ld = 0; e_rd = 0;
      bubble();
    end else if (!m_busy) begin
      if ((ld | st) && ALIGN && alu[1:0] != 2'b00) begin
        e_alu = alu; e_rd = rd; bubble(); e_mis = 1;
      end else if (ld | st) begin
        m_busy = 1; m_wait = 1;
        e_req = 1; e_we = st; e_addr = alu[31:2]; e_wdata = op2; bubble();
      end else begin
        e_alu = alu; e_rd = rd; bubble(); e_wb = wb;
      end
    end else if (ack) begin
      m_busy = 0; e_req = 0; e_alu = alu; e_rd = rd; bubble(); e_wb = wb; e_isld = ld;
      if (ld) e_ld = rdata;
    end else if (m_wait == TIMEOUT) begin
      m_busy = 0; e_req = 0; e_alu = alu; e_rd = rd; bubble(); e_err = 1;
    end else begin
      m_wait++; bubble();
    end
    @(negedge clk);
    chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
    chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
    chk("mem_addr", {2'b0, mem_addr}, {2'b0, e_addr});
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("aluResult_RW", aluResult_RW, e_alu);
    chk("ldResult_RW", ldResult_RW, e_ld);
    chk("rd_RW", {27'b0, rd_RW}, {27'b0, e_rd});
    chk("isWb_RW", {31'b0, isWb_RW}, {31'b0, e_wb});
    chk("isLd_RW", {31'b0, isLd_RW}, {31'b0, e_isld});
    chk("memErr_RW", {31'b0, memErr_RW}, {31'b0, e_err});
    chk("misalign_RW", {31'b0, misalign_RW}, {31'b0, e_mis});
  endtask
  initial begin
    logic [31:0] a, o;
    logic [4:0] rdv;
    logic w, l, s, rr, ak, hold;
    int lat, k;
    rst = 1; aluResult_DM = 0; op2_DM = 0; rd_DM = 0; isWb_DM = 0; isLd_DM = 0; isSt_DM = 0;
    mem_ack = 0; mem_rdata = 0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_reset_req", {31'b0, mem_req}, 32'd0);
    chk("lit_reset_alu", aluResult_RW, 32'd0);
    stall_cnt = 0;
    cyc(0, 32'h10, 0, 5'd3, 1, 0, 0, 0, 0);
    chk("lit_add_alu", aluResult_RW, 32'h10);
    chk("lit_add_rd", {27'b0, rd_RW}, 32'd3);
    chk("lit_add_wb", {31'b0, isWb_RW}, 32'd1);
    chk("lit_add_stall", stall_cnt, 32'd0);
    stall_cnt = 0;
    cyc(0, 32'h40, 0, 5'd5, 1, 1, 0, 0, 0);
    chk("lit_ld_addr", {2'b0, mem_addr}, 32'h10);
    chk("lit_ld_we", {31'b0, mem_we}, 32'd0);
    cyc(0, 32'h40, 0, 5'd5, 1, 1, 0, 0, 32'h0);
    cyc(0, 32'h40, 0, 5'd5, 1, 1, 0, 0, 32'h0);
    cyc(0, 32'h40, 0, 5'd5, 1, 1, 0, 1, 32'hDEADBEEF);
    chk("lit_ld_stall", stall_cnt, 32'd3);
    chk("lit_ld_data", ldResult_RW, 32'hDEADBEEF);
    chk("lit_ld_isld", {31'b0, isLd_RW}, 32'd1);
    chk("lit_ld_wb", {31'b0, isWb_RW}, 32'd1);
    req_cnt = 0;
    cyc(0, 32'h8, 32'h1234, 5'd0, 0, 0, 1, 0, 0);
    chk("lit_st_we", {31'b0, mem_we}, 32'd1);
    chk("lit_st_wdata", mem_wdata, 32'h1234);
    cyc(0, 32'h8, 32'h1234, 5'd0, 0, 0, 1, 1, 0);
    chk("lit_st_reqcycles", req_cnt, 32'd1);
    chk("lit_st_wb", {31'b0, isWb_RW}, 32'd0);
    req_cnt = 0;
    cyc(0, 32'h20, 0, 5'd9, 1, 1, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) cyc(0, 32'h20, 0, 5'd9, 1, 1, 0, 0, 0);
    chk("lit_to_reqcycles", req_cnt, TIMEOUT);
    chk("lit_to_err", {31'b0, memErr_RW}, 32'd1);
    chk("lit_to_wb", {31'b0, isWb_RW}, 32'd0);
    chk("lit_to_req", {31'b0, mem_req}, 32'd0);
    cyc(0, 32'h0, 0, 5'd0, 0, 0, 0, 1, 32'h55);
    chk("lit_late_ack_req", {31'b0, mem_req}, 32'd0);
    chk("lit_late_ack_ld", ldResult_RW, 32'hDEADBEEF);
    cyc(0, 32'h30, 0, 5'd4, 1, 1, 0, 0, 0);
    cyc(0, 32'h30, 0, 5'd4, 1, 1, 0, 0, 0);
    cyc(1, 32'h30, 0, 5'd4, 1, 1, 0, 0, 0);
    chk("lit_rst_req", {31'b0, mem_req}, 32'd0);
    chk("lit_rst_rd", {27'b0, rd_RW}, 32'd0);
    stall_cnt = 0;
    cyc(0, 32'h55, 0, 5'd7, 1, 0, 0, 0, 0);
    chk("lit_rst_add", aluResult_RW, 32'h55);
    chk("lit_rst_stall", stall_cnt, 32'd0);
    cyc(0, 32'h41, 0, 5'd2, 1, 1, 0, 0, 0);
    if (ALIGN) begin
      chk("lit_mis_flag", {31'b0, misalign_RW}, 32'd1);
      chk("lit_mis_req", {31'b0, mem_req}, 32'd0);
    end else begin
      chk("lit_mis_addr", {2'b0, mem_addr}, 32'h10);
      cyc(0, 32'h41, 0, 5'd2, 1, 1, 0, 1, 32'hCAFE);
    end
    hold = 0; lat = 1; a = 0; o = 0; rdv = 0; w = 0; l = 0; s = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        k = $urandom_range(0, 9);
        a = $urandom; o = $urandom; rdv = 5'($urandom); w = 1'($urandom);
        l = k >= 5 && k <= 7; s = k >= 8;
        if ((l | s) && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      end
      rr = $urandom_range(0, 99) == 0;
      if (!m_busy) lat = $urandom_range(1, TIMEOUT + 3);
      ak = m_busy ? (m_wait == lat) : ($urandom_range(0, 7) == 0);
      cyc(rr, a, o, rdv, w, l, s, ak, $urandom);
      hold = exp_stall;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
